// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB requester bridge with ACCESS-phase timeout.
module apb_master_bridge #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   // command side
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // response side
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   // APB requester
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
   logic                  cmd_ready_nxt;
   logic                  psel_nxt, penable_nxt, pwrite_nxt;
   logic [ADDR_WIDTH-1:0] paddr_nxt;
   logic [DATA_WIDTH-1:0] pwdata_nxt;
   logic                  rsp_valid_nxt, rsp_err_nxt;
   logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

   // Next state and next values of every registered output.
   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      cmd_ready_nxt = 1'b0;
      psel_nxt      = 1'b0;
      penable_nxt   = 1'b0;
      pwrite_nxt    = PWRITE;
      paddr_nxt     = PADDR;
      pwdata_nxt    = PWDATA;
      rsp_valid_nxt = 1'b0;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;

      case (state)
         IDLE: begin
            cmd_ready_nxt = 1'b1;
            if (cmd_valid) begin
               state_nxt     = SETUP;
               cmd_ready_nxt = 1'b0;
               psel_nxt      = 1'b1;
               pwrite_nxt    = cmd_write;
               paddr_nxt     = cmd_addr;
               pwdata_nxt    = cmd_wdata;
               wait_cnt_nxt  = '0;
            end
         end
         SETUP: begin
            state_nxt   = ACCESS;
            psel_nxt    = 1'b1;
            penable_nxt = 1'b1;
         end
         ACCESS: begin
            psel_nxt    = 1'b1;
            penable_nxt = 1'b1;
            if (PREADY) begin
               // completion wins over a timeout reached in the same cycle
               state_nxt     = RESP;
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b0;
               rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
            end else begin
               wait_cnt_nxt = wait_cnt + CNT_W'(1);
               if (wait_cnt == WAIT_LAST) begin
                  state_nxt     = RESP;
                  psel_nxt      = 1'b0;
                  penable_nxt   = 1'b0;
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = 1'b1;
                  rsp_rdata_nxt = '0;
               end
            end
         end
         RESP: begin
            rsp_valid_nxt = 1'b1;
            if (rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
               cmd_ready_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt     = IDLE;
            cmd_ready_nxt = 1'b1;
         end
      endcase
   end

   // State, wait counter and output registers.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         cmd_ready <= 1'b1;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         cmd_ready <= cmd_ready_nxt;
         PSEL      <= psel_nxt;
         PENABLE   <= penable_nxt;
         PWRITE    <= pwrite_nxt;
         PADDR     <= paddr_nxt;
         PWDATA    <= pwdata_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         rsp_err   <= rsp_err_nxt;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomised transaction-level check of apb_master_bridge against a per-cycle expectation model.
module tb_apb_master_bridge;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned TO = 4;

   logic          PCLK, PRESETn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          PSEL, PENABLE, PWRITE, PREADY;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;

   apb_master_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // expected DUT outputs for the current cycle
   logic          e_cmd_ready, e_psel, e_penable, e_pwrite, e_rsp_valid, e_rsp_err;
   logic [AW-1:0] e_paddr;
   logic [DW-1:0] e_pwdata, e_rsp_rdata;

   // DUT values observed during the last transaction
   int            obs_access;
   logic          obs_setup_psel, obs_setup_penable, obs_valid, obs_err;
   logic [DW-1:0] obs_rdata;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of DUT outputs against the expectation model.
   always @(negedge PCLK) begin
      if (chk_en) begin
         if (PRESETn) check("cmd_ready", 64'(cmd_ready), 64'(e_cmd_ready));
         check("PSEL",      64'(PSEL),      64'(e_psel));
         check("PENABLE",   64'(PENABLE),   64'(e_penable));
         check("PWRITE",    64'(PWRITE),    64'(e_pwrite));
         check("PADDR",     64'(PADDR),     64'(e_paddr));
         check("PWDATA",    64'(PWDATA),    64'(e_pwdata));
         check("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
         if (e_rsp_valid) begin
            check("rsp_rdata", 64'(rsp_rdata), 64'(e_rsp_rdata));
            check("rsp_err",   64'(rsp_err),   64'(e_rsp_err));
         end
      end
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic set_reset_exp();
      e_cmd_ready = 1'b1; e_psel = 1'b0; e_penable = 1'b0; e_pwrite = 1'b0;
      e_paddr = '0; e_pwdata = '0; e_rsp_valid = 1'b0; e_rsp_rdata = '0; e_rsp_err = 1'b0;
   endtask

   // Command-side noise while the bridge is busy; none of it may be accepted.
   task automatic drive_busy(input bit hold_valid);
      cmd_valid = hold_valid ? 1'b1 : 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = 32'($urandom);
      cmd_wdata = 32'($urandom);
   endtask

   // One full transfer: n_wait ACCESS cycles with PREADY low before PREADY high.
   task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] rdata, input int n_wait, input int resp_delay,
                          input int gap, input bit hold_valid);
      bit timeout;
      int n_access;
      timeout  = (n_wait >= int'(TO));
      n_access = timeout ? int'(TO) : n_wait + 1;

      repeat (gap) begin
         cmd_valid = 1'b0; PREADY = 1'($urandom); rsp_ready = 1'($urandom);
         tick();
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      PREADY = 1'($urandom); rsp_ready = 1'($urandom);
      tick();
      e_cmd_ready = 1'b0; e_psel = 1'b1; e_penable = 1'b0;
      e_pwrite = wr; e_paddr = addr; e_pwdata = wdata;
      obs_setup_psel = PSEL; obs_setup_penable = PENABLE;

      drive_busy(hold_valid); PREADY = 1'($urandom); rsp_ready = 1'($urandom);
      tick();
      e_penable = 1'b1;

      obs_access = 0;
      for (int k = 0; k < n_access; k++) begin
         if (PSEL && PENABLE) obs_access++;
         drive_busy(hold_valid);
         rsp_ready = 1'($urandom);
         PREADY    = (k == n_wait);
         PRDATA    = (k == n_wait) ? rdata : 32'($urandom);
         tick();
      end
      e_psel = 1'b0; e_penable = 1'b0; e_rsp_valid = 1'b1;
      e_rsp_err   = timeout;
      e_rsp_rdata = (timeout || wr) ? '0 : rdata;
      obs_valid = rsp_valid; obs_rdata = rsp_rdata; obs_err = rsp_err;

      repeat (resp_delay) begin
         drive_busy(hold_valid); rsp_ready = 1'b0; PREADY = 1'($urandom);
         tick();
      end
      drive_busy(hold_valid); rsp_ready = 1'b1; PREADY = 1'($urandom);
      tick();
      e_rsp_valid = 1'b0; e_cmd_ready = 1'b1;
      rsp_ready = 1'b0; cmd_valid = 1'b0;
   endtask

   initial begin
      PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0;
      set_reset_exp();
      chk_en = 1'b1;
      repeat (2) tick();
      PRESETn = 1'b1;
      tick();
      check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
      check("reset_psel", 64'(PSEL), 64'(0));

      // write, PREADY on first ACCESS cycle
      run_txn(1'b1, 32'h8, 32'hDEADBEEF, 32'h0, 0, 0, 0, 1'b0);
      check("wr_setup_psel", 64'(obs_setup_psel), 64'(1));
      check("wr_setup_penable", 64'(obs_setup_penable), 64'(0));
      check("wr_access_cycles", 64'(obs_access), 64'(1));
      check("wr_rsp_valid", 64'(obs_valid), 64'(1));
      check("wr_rsp_rdata", 64'(obs_rdata), 64'(0));
      check("wr_rsp_err", 64'(obs_err), 64'(0));

      // read with two wait cycles
      run_txn(1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 2, 0, 1, 1'b0);
      check("rd_access_cycles", 64'(obs_access), 64'(3));
      check("rd_rsp_rdata", 64'(obs_rdata), 64'(32'hDEADBEEF));
      check("rd_rsp_err", 64'(obs_err), 64'(0));

      // timeout: PREADY never rises
      run_txn(1'b0, 32'h40, 32'h0, 32'h12345678, 10, 0, 1, 1'b0);
      check("to_access_cycles", 64'(obs_access), 64'(4));
      check("to_rsp_err", 64'(obs_err), 64'(1));
      check("to_rsp_rdata", 64'(obs_rdata), 64'(0));

      // PREADY on the last allowed ACCESS cycle completes normally
      run_txn(1'b0, 32'h44, 32'h0, 32'hCAFEF00D, 3, 0, 1, 1'b0);
      check("edge_access_cycles", 64'(obs_access), 64'(4));
      check("edge_rsp_err", 64'(obs_err), 64'(0));
      check("edge_rsp_rdata", 64'(obs_rdata), 64'(32'hCAFEF00D));

      // response back-pressure with a pending command, then back-to-back accept
      run_txn(1'b0, 32'h80, 32'h0, 32'hA5A5A5A5, 1, 5, 0, 1'b1);
      run_txn(1'b1, 32'h84, 32'h11223344, 32'h0, 0, 0, 0, 1'b0);
      check("b2b_access_cycles", 64'(obs_access), 64'(1));

      // reset pulse during ACCESS
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hC0; cmd_wdata = '0; PREADY = 1'b0;
      tick();
      e_cmd_ready = 1'b0; e_psel = 1'b1; e_penable = 1'b0;
      e_pwrite = 1'b0; e_paddr = 32'hC0; e_pwdata = '0;
      cmd_valid = 1'b0;
      tick();
      e_penable = 1'b1;
      #1;
      PRESETn = 1'b0;
      set_reset_exp();
      #1;
      check("rst_psel", 64'(PSEL), 64'(0));
      check("rst_penable", 64'(PENABLE), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      tick();
      tick();
      PRESETn = 1'b1;
      tick();
      run_txn(1'b0, 32'hC4, 32'h0, 32'h0BADF00D, 1, 1, 0, 1'b0);
      check("post_rst_rdata", 64'(obs_rdata), 64'(32'h0BADF00D));

      // randomised traffic
      for (int i = 0; i < 60; i++) begin
         run_txn(1'($urandom), 32'($urandom) & 32'hFFFF_FFFC, 32'($urandom), 32'($urandom),
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), 1'($urandom));
      end

      tick();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
